// File: rtl/int_divider.sv
// Iterative restoring integer divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow finish in a single cycle without iterating.
module int_divider #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            IDiv,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Src1,
  input  logic [XLEN-1:0] Src2,
  input  logic            Flush,
  output logic [XLEN-1:0] Div_Result,
  output logic            Div_Valid,
  output logic            Div_Busy
);

  // state | meaning
  // IDLE  | waiting for a request
  // CALC  | shift-subtract iterations in progress
  // DONE  | Div_Result valid for one cycle
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [1:0]      op_q, op_d;
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;

  logic            accept, op_signed, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, diff;
  logic            qbit;
  logic [XLEN-1:0] rem_n, quo_n, q_out, r_out;
  logic            unused_funct3;

  assign unused_funct3 = Funct3[2];

  always_comb begin
    accept    = (state_q == IDLE) && IDiv && !Flush;
    op_signed = !Funct3[0];
    a_neg     = op_signed && Src1[XLEN-1];
    b_neg     = op_signed && Src2[XLEN-1];
    a_mag     = a_neg ? ('0 - Src1) : Src1;
    b_mag     = b_neg ? ('0 - Src2) : Src2;
    div_zero  = (Src2 == '0);
    ovf       = op_signed && (Src1 == MIN_NEG) && (Src2 == '1);

    // Partial remainder is always below the divisor, so the difference fits XLEN bits.
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    qbit    = !diff[XLEN];
    rem_n   = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], qbit};
    q_out   = (qsign_q && op_q == 2'b00) ? ('0 - quo_n) : quo_n;
    r_out   = (rsign_q && op_q == 2'b10) ? ('0 - rem_n) : rem_n;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    op_d    = op_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = Funct3[1:0];
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          cnt_d   = XLEN'(XLEN - 1);
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          if (div_zero) begin
            state_d = DONE;
            res_d   = Funct3[1] ? Src1 : '1;
          end else if (ovf) begin
            state_d = DONE;
            res_d   = Funct3[1] ? '0 : MIN_NEG;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
            res_d   = op_q[1] ? r_out : q_out;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      op_q    <= op_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
    end
  end

  assign Div_Result = res_q;
  assign Div_Valid  = (state_q == DONE);
  assign Div_Busy   = (state_q == CALC) || accept;

endmodule

// File: tb/tb_int_divider.sv
// Directed bench for int_divider: results, latency, busy window, flush and reset abort.
module tb_int_divider;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        IDiv = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Src1 = '0;
  logic [31:0] Src2 = '0;
  logic        Flush = 1'b0;
  logic [31:0] Div_Result;
  logic        Div_Valid;
  logic        Div_Busy;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] F_DIV = 3'b000, F_DIVU = 3'b001, F_REM = 3'b010, F_REMU = 3'b011;

  int_divider #(.XLEN(32)) dut (
    .CLK(CLK), .rst_n(rst_n), .IDiv(IDiv), .Funct3(Funct3), .Src1(Src1), .Src2(Src2),
    .Flush(Flush), .Div_Result(Div_Result), .Div_Valid(Div_Valid), .Div_Busy(Div_Busy)
  );

  always #5 CLK = ~CLK;

  // Issues one request and reports result, latency (accept edge = cycle 1) and busy cycles seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_idiv, output logic [31:0] res, output int lat,
                        output int busy_cnt, output bit timeout);
    @(negedge CLK);
    IDiv = 1'b1; Funct3 = f; Src1 = a; Src2 = b;
    @(posedge CLK);
    res = 'x; lat = 0; busy_cnt = 0; timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (Div_Valid) begin
        lat = i + 1; res = Div_Result; timeout = 1'b0;
        IDiv = 1'b0;
        break;
      end
      if (Div_Busy) busy_cnt++;
      if (!hold_idiv) IDiv = 1'b0;
    end
    IDiv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (Div_Valid !== 1'b0 || Div_Busy !== 1'b0 || Div_Result !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b busy=%b res=%h exp 0 0 00000000",
               Div_Valid, Div_Busy, Div_Result);
    end
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (Div_Valid !== 1'b0 || Div_Busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got valid=%b busy=%b exp 0 0", Div_Valid, Div_Busy);
    end
  endtask

  task automatic test_unsigned();
    logic [2:0]  fv [4] = '{F_DIVU, F_REMU, F_DIVU, F_REMU};
    logic [31:0] av [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bv [4] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'h0000_0010};
    logic [31:0] ev [4] = '{32'd14, 32'd2, 32'd0, 32'h0000_000F};
    logic [31:0] r; int lat, busy; bit to;
    for (int k = 0; k < 4; k++) begin
      run_op(fv[k], av[k], bv[k], 1'b0, r, lat, busy, to);
      checks++;
      if (to || r !== ev[k] || lat != 33 || busy != 32) begin
        failures++;
        $display("FAIL unsigned_%0d got res=%h lat=%0d busy=%0d to=%0b exp res=%h lat=33 busy=32",
                 k, r, lat, busy, to, ev[k]);
      end
      @(negedge CLK);
      checks++;
      if (Div_Valid !== 1'b0) begin
        failures++;
        $display("FAIL valid_pulse_%0d got valid=%b exp 0", k, Div_Valid);
      end
    end
  endtask

  task automatic test_signed();
    logic [2:0]  fv [4] = '{F_DIV, F_REM, F_DIV, F_REM};
    logic [31:0] av [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
    logic [31:0] bv [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] ev [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
    logic [31:0] r; int lat, busy; bit to;
    for (int k = 0; k < 4; k++) begin
      run_op(fv[k], av[k], bv[k], 1'b0, r, lat, busy, to);
      checks++;
      if (to || r !== ev[k] || lat != 33) begin
        failures++;
        $display("FAIL signed_%0d got res=%h lat=%0d to=%0b exp res=%h lat=33",
                 k, r, lat, to, ev[k]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv [4] = '{F_DIVU, F_REM, F_DIV, F_REM};
    logic [31:0] av [4] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd0};
    logic [31:0] r; int lat, busy; bit to;
    for (int k = 0; k < 4; k++) begin
      run_op(fv[k], av[k], bv[k], 1'b0, r, lat, busy, to);
      checks++;
      if (to || r !== ev[k] || lat != 1 || busy != 0) begin
        failures++;
        $display("FAIL special_%0d got res=%h lat=%0d busy=%0d to=%0b exp res=%h lat=1 busy=0",
                 k, r, lat, busy, to, ev[k]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, r; int lat, busy; bit to, seen;
    prev = Div_Result;
    @(negedge CLK);
    IDiv = 1'b1; Funct3 = F_DIVU; Src1 = 32'd1000; Src2 = 32'd3;
    @(posedge CLK);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      IDiv = 1'b0;
    end
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    checks++;
    if (Div_Busy !== 1'b0 || Div_Valid !== 1'b0 || Div_Result !== prev) begin
      failures++;
      $display("FAIL flush_idle got busy=%b valid=%b res=%h exp 0 0 %h",
               Div_Busy, Div_Valid, Div_Result, prev);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (Div_Valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL flush_no_valid got valid_seen=1 exp 0");
    end
    run_op(F_DIVU, 32'd9, 32'd3, 1'b0, r, lat, busy, to);
    checks++;
    if (to || r !== 32'd3 || lat != 33) begin
      failures++;
      $display("FAIL after_flush got res=%h lat=%0d to=%0b exp res=00000003 lat=33", r, lat, to);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] r; int lat, busy; bit to, seen;
    @(negedge CLK);
    IDiv = 1'b1; Funct3 = F_DIV; Src1 = 32'd12345; Src2 = 32'd11;
    @(posedge CLK);
    repeat (5) @(negedge CLK);
    rst_n = 1'b0; IDiv = 1'b0;
    #1;
    checks++;
    if (Div_Valid !== 1'b0 || Div_Busy !== 1'b0 || Div_Result !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_calc got valid=%b busy=%b res=%h exp 0 0 00000000",
               Div_Valid, Div_Busy, Div_Result);
    end
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (Div_Valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_no_valid got valid_seen=1 exp 0");
    end
    run_op(F_DIVU, 32'd100, 32'd7, 1'b1, r, lat, busy, to);
    checks++;
    if (to || r !== 32'd14 || lat != 33 || busy != 32) begin
      failures++;
      $display("FAIL idiv_held got res=%h lat=%0d busy=%0d to=%0b exp res=0000000e lat=33 busy=32",
               r, lat, busy, to);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_divider.md
INT_DIVIDER -- requirements
Module: int_divider

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port IDiv, input, 1 bit: divide request from the IALU control decoder.
REQ-005 SHALL have port Funct3, input, 3 bits; only bits [1:0] are used: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port Src1, input, XLEN bits: dividend.
REQ-007 SHALL have port Src2, input, XLEN bits: divisor.
REQ-008 SHALL have port Flush, input, 1 bit: abort any operation in progress.
REQ-009 SHALL have port Div_Result, output, XLEN bits: quotient or remainder, registered.
REQ-010 SHALL have port Div_Valid, output, 1 bit: result-valid pulse.
REQ-011 SHALL have port Div_Busy, output, 1 bit: stall request to the pipeline.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 SHALL accept a request only in IDLE with IDiv=1 and Flush=0, latching Funct3[1:0], Src1 and Src2 on that edge (the accept edge); IDiv in CALC or DONE SHALL be ignored.
REQ-014 SHALL treat operands as signed for DIV/REM and unsigned for DIVU/REMU, converting signed operands to magnitudes at accept and recording the quotient sign (Src1[XLEN-1] XOR Src2[XLEN-1]) and the remainder sign (Src1[XLEN-1]).
REQ-015 SHALL, for a normal request, move IDLE->CALC at the accept edge and perform XLEN restoring shift-subtract iterations, one quotient bit per cycle, MSB first, using an XLEN-bit iteration counter.
REQ-016 SHALL move CALC->DONE on the edge that completes iteration XLEN, apply the sign correction, and register Div_Result on that same edge.
REQ-017 SHALL handle divisor zero by going IDLE->DONE at the accept edge with quotient all ones and remainder equal to Src1 unmodified.
REQ-018 SHALL handle DIV/REM with Src1=2^(XLEN-1) and Src2=all ones (signed overflow) by going IDLE->DONE at the accept edge with quotient 2^(XLEN-1) and remainder 0.
REQ-019 SHALL drive Div_Valid high for exactly the one cycle spent in DONE, and SHALL always move DONE->IDLE on the next edge.
REQ-020 SHALL hold Div_Result stable from DONE until the next DONE; Div_Result is meaningful only while Div_Valid=1.
REQ-021 SHALL drive Div_Busy combinationally as (state==CALC) OR (state==IDLE AND IDiv=1 AND Flush=0), so the requesting instruction stalls from its first cycle.
REQ-022 SHALL give the following latency from the accept edge to Div_Valid high: XLEN+1 cycles for normal operations and 1 cycle for the REQ-017/018 special cases.
REQ-023 SHALL, when Flush=1 in CALC, go to IDLE on the next edge with no Div_Valid and Div_Result unchanged.
REQ-024 SHALL ignore Flush in DONE, so the pulse in progress completes.
REQ-025 SHALL apply the sign rules as follows: a negative quotient is negated only for DIV, a negative remainder only for REM, and the sign of a nonzero remainder equals the dividend sign.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state IDLE, Div_Valid=0, Div_Busy=0 (with IDiv=0), Div_Result=0, and clear the counter and all working registers.
REQ-027 SHALL, when reset is asserted mid-CALC, abandon the operation with no Div_Valid after release; the first request after release SHALL behave as from power-up.

Verification
REQ-028 SHALL verify DIVU: Src1=100, Src2=7 -> Div_Busy high for 32 cycles; Div_Valid exactly 33 cycles after the accept edge; Div_Result=14. Repeat with REMU -> Div_Result=2.
REQ-029 SHALL verify DIV/REM: Src1=-7, Src2=2 -> DIV gives 0xFFFFFFFD (-3); REM gives 0xFFFFFFFF (-1); same for Src1=7, Src2=-2 gives -3 and +1.
REQ-030 SHALL verify division by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/0 -> 0x80000000; Div_Valid 1 cycle after the accept edge.
REQ-031 SHALL verify overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; 1-cycle latency.
REQ-032 SHALL verify Flush at CALC cycle 10 -> IDLE next cycle; no Div_Valid; a following DIVU 9/3 gives 3 with normal latency.
REQ-033 SHALL verify rst_n low at CALC cycle 5 -> outputs 0 immediately; after release no Div_Valid; IDiv held high during CALC is ignored and the result is unaffected.
